// File: rtl/latch_loader_pkg.sv
// Shared definitions for the latch loader: FSM state encoding and counter sizing.
// Latency: none (declarations only).
// Backpressure: not applicable.
package latch_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_SETUP = ST_SETUP,
        S_LOAD  = ST_LOAD,
        S_HOLD  = ST_HOLD
    } state_t;

    // Bits needed for a counter that must reach the value n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in parallel-out shift register, MSB first, with synchronous clear.
// Latency: a shifted bit is visible on o_q one cycle after i_shift_en.
// Backpressure: none; shifts only when i_shift_en is high, clear has priority.
module sipo_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    // A one-bit register has no older bits to keep, so it simply takes the new bit.
    generate
        if (WIDTH == 1) begin : g_one
            assign w_shifted = i_sin;
        end else begin : g_wide
            assign w_shifted = {r_q[WIDTH-2:0], i_sin};
        end
    endgenerate

    // Shift state: reset and clear to zero, otherwise shift on enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= w_shifted;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/latch_loader.sv
// Assembles a serial word and loads it into a D-latch bank with a guarded en window.
// Latency: d updates 1 cycle after the last bit, en high cycles 2..EN_CYCLES+1 after it.
// Backpressure: sin_valid=0 stalls shifting indefinitely; start is ignored while busy.
module latch_loader
    import latch_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] d,
    output logic             en,
    output logic             busy,
    output logic             done
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int LCW = cnt_width(EN_CYCLES);
    localparam logic [BCW-1:0] BIT_FULL = BCW'(WIDTH);
    localparam logic [LCW-1:0] LD_LAST  = LCW'(EN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [LCW-1:0]   r_ld_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_shreg;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic             w_full;
    logic             w_shift_en;
    logic             w_clr;

    // The word is complete once the counter holds WIDTH; further bits are ignored
    // until the FSM leaves SHIFT. Abort blocks the shift of a coincident bit.
    assign w_full     = (r_bit_cnt == BIT_FULL);
    assign w_shift_en = (r_state == S_SHIFT) && sin_valid && !abort && !w_full;
    assign w_clr      = (r_state == S_IDLE) && start && !abort;

    sipo_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_shift_en (w_shift_en),
        .i_sin      (sin),
        .o_q        (w_shreg)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort only matters in SHIFT, start only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_full) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (r_ld_cnt == LD_LAST) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit counter clears on frame start; LOAD counter runs only while in LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_ld_cnt  <= '0;
        end else begin
            if (w_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end

            if (r_state == S_LOAD) begin
                r_ld_cnt <= r_ld_cnt + LCW'(1);
            end else begin
                r_ld_cnt <= '0;
            end
        end
    end

    // Latch data register: captured only on the edge entering SETUP, so it is
    // stable a full cycle before en rises and until well after en falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d <= '0;
        end else if ((r_state == S_SHIFT) && (w_state_nxt == S_SETUP)) begin
            r_d <= w_shreg;
        end
    end

    // Control outputs come straight from flops so en cannot glitch on state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_en   <= (w_state_nxt == S_LOAD);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_HOLD);
        end
    end

    assign d    = r_d;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_latch_loader.sv
// Scoreboarded bench for latch_loader: directed frames with hand-computed words.
// Latency: checks d one cycle before en, en width, done after en, and stalls.
// Backpressure: exercises sin_valid stalls, aborts, mid-LOAD reset, back-to-back start.
module tb_latch_loader;

    localparam int WIDTH     = 8;
    localparam int EN_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    latch_loader #(
        .WIDTH     (WIDTH),
        .EN_CYCLES (EN_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .sin       (sin),
        .sin_valid (sin_valid),
        .d         (d),
        .en        (en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and drive just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one frame. abort_at >= 0 raises abort together with that bit index.
    // On a completed frame the expected word is pushed to the scoreboard and the
    // SETUP / en-rise latency is checked relative to the last accepted bit.
    task automatic send_frame(input logic [WIDTH-1:0] w, input bit stall, input int abort_at);
        logic [WIDTH-1:0] wv;
        wv = w;
        if (abort_at < 0) exp_q.push_back(wv);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (stall) begin
                sin_valid = 1'b0;
                sin       = ~wv[WIDTH-1-i];
                tick();
            end
            sin       = wv[WIDTH-1-i];
            sin_valid = 1'b1;
            abort     = (i == abort_at);
            tick();
            abort     = 1'b0;
            sin_valid = 1'b0;
            if (i == abort_at) break;
        end
        sin = 1'b0;
        if (abort_at < 0) begin
            check("en_low_at_last_bit", 32'(en), 32'd0);
            tick();
            check("d_at_setup", 32'(d), 32'(wv));
            check("en_low_in_setup", 32'(en), 32'd0);
            tick();
            check("en_rise_k_plus_2", 32'(en), 32'd1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: en window shape, d stability around the window, done pulse and
    // scoreboard pop whenever the DUT signals a completed load.
    logic             prev_en   = 1'b0;
    logic             prev_done = 1'b0;
    logic [WIDTH-1:0] prev_d    = '0;
    int               en_len    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   <= 1'b0;
            prev_done <= 1'b0;
            prev_d    <= d;
            en_len    <= 0;
        end else begin
            if (en || prev_en) begin
                check("d_stable_window", 32'(d), 32'(prev_d));
            end
            if (en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    check("en_unexpected", 32'(en), 32'd0);
                end else begin
                    check("d_at_en_rise", 32'(d), 32'(exp_q[0]));
                end
            end
            if (en) en_len <= (prev_en ? en_len + 1 : 1);
            if (done) begin
                check("done_single_pulse", 32'(prev_done), 32'd0);
                check("done_after_en_fall", 32'({prev_en, en}), 32'b10);
                check("en_window_len", 32'(en_len), 32'(EN_CYCLES));
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    check("d_at_done", 32'(d), 32'(exp_q.pop_front()));
                end
            end
            prev_en   <= en;
            prev_done <= done;
            prev_d    <= d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected done", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;

        // Reset with random input activity.
        repeat (2) begin
            start     = 1'($urandom);
            abort     = 1'($urandom);
            sin       = 1'($urandom);
            sin_valid = 1'($urandom);
            tick();
        end
        check("rst_d", 32'(d), 32'h00);
        check("rst_en", 32'(en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Nominal back-to-back bits.
        send_frame(8'hA5, 1'b0, -1);
        wait_idle("idle_after_nominal");
        check("d_kept_nominal", 32'(d), 32'hA5);

        // Alternate-cycle stalls.
        send_frame(8'hA5, 1'b1, -1);
        wait_idle("idle_after_stall");

        // Load 3C, then abort after 5 bits and abort coincident with the 8th bit.
        send_frame(8'h3C, 1'b0, -1);
        wait_idle("idle_after_3c");
        send_frame(8'hF0, 1'b0, 5);
        check("abort5_busy_low", 32'(busy), 32'd0);
        check("abort5_d_kept", 32'(d), 32'h3C);
        repeat (4) tick();
        send_frame(8'hC3, 1'b0, 7);
        check("abort8_busy_low", 32'(busy), 32'd0);
        repeat (4) tick();
        check("abort8_d_kept", 32'(d), 32'h3C);
        check("abort8_en_low", 32'(en), 32'd0);

        // Reset during the first en cycle.
        send_frame(8'h81, 1'b0, -1);
        rst_n = 1'b0;
        tick();
        check("midload_en", 32'(en), 32'd0);
        check("midload_d", 32'(d), 32'h00);
        check("midload_busy", 32'(busy), 32'd0);
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        check("midload_still_idle", 32'(busy), 32'd0);

        // start during LOAD is ignored; start in the first IDLE cycle is taken.
        send_frame(8'h96, 1'b0, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("b2b_done_in_hold", 32'(done), 32'd1);
        tick();
        check("b2b_first_idle", 32'(busy), 32'd0);
        send_frame(8'hFF, 1'b0, -1);
        wait_idle("idle_after_ff");
        check("d_final_ff", 32'(d), 32'hFF);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_loader.md
# latch_loader

Serial-to-parallel loader that sits directly upstream of the D-latch bank. It assembles a WIDTH-bit word from a serial bit stream and presents it on `d`. It then opens the latches with an `en` window, holding `d` stable one cycle before and one cycle after that window so the level-sensitive latches never see data change while transparent. It is fully synchronous, and its `en` and `d` outputs drive the latch `en`/`d` inputs directly.

## Interface
Parameters:
- `WIDTH`, 8: word width; one latch per bit; must be >= 1.
- `EN_CYCLES`, 2: number of cycles `en` is held high per load; must be >= 1.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: begin a frame; sampled only in IDLE.
- `abort` input 1: abandon the frame in progress; sampled in SHIFT.
- `sin` input 1: serial data bit, MSB first.
- `sin_valid` input 1: `sin` is valid this cycle.
- `d` output WIDTH: word presented to the latch bank.
- `en` output 1: latch enable (transparent while high).
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a load window completes.

## Operation
- States: IDLE, SHIFT, SETUP, LOAD, HOLD.
- **IDLE**
  - `start`=1 and `abort`=0 -> SHIFT, and the bit counter clears.
  - `sin` in the start cycle is ignored.
- **SHIFT**
  - Each cycle with `sin_valid`=1: `shreg <= {shreg[WIDTH-2:0], sin}` and count+1.
  - Cycles with `sin_valid`=0 are stalls with no change; there is no timeout.
  - When the WIDTH-th bit is accepted -> SETUP.
  - `abort`=1 -> IDLE; `d` is untouched and the partial word is discarded. Abort wins over a simultaneous last bit.
- **SETUP**: `d <= shreg` on entry; `en`=0; next state is LOAD.
- **LOAD**: `en`=1 for exactly EN_CYCLES cycles, then HOLD. `d` is frozen.
- **HOLD**: `en`=0, `d` frozen, `done`=1 for this cycle only; next state is IDLE.
- `start` is ignored in every state except IDLE. `abort` is ignored outside SHIFT.
- `d` changes only on the edge entering SETUP. It keeps the last loaded word indefinitely, including across aborts.
- Counter width is $clog2(WIDTH+1). The LOAD-cycle counter width is $clog2(EN_CYCLES+1).
- Reset values: `d`=0, `en`=0, `busy`=0, `done`=0, shift register 0, counters 0, state IDLE.

## Timing
- `en`, `busy` and `done` are registered or decoded from registered state only, with no combinational path from inputs. `en` must be glitch-free.
- Let the last bit be accepted at edge k:
  - SETUP and new `d` from edge k+1.
  - `en` high from edge k+2 through edge k+1+EN_CYCLES.
  - HOLD (`done`=1) at edge k+2+EN_CYCLES.
  - IDLE at edge k+3+EN_CYCLES.
- Minimum frame with back-to-back valid bits: 1 (start) + WIDTH + 1 + EN_CYCLES + 1 cycles from `start` to IDLE.
- A new `start` is accepted in the first IDLE cycle after HOLD.
- `busy` rises the cycle after `start` is sampled and falls on the edge into IDLE.
- `rst_n`=0 sampled at any edge, mid-frame included, forces all reset values at that edge. `en` drops at that edge even mid-LOAD, and `d` returns to 0.

## Structure
- Shared package `latch_loader_pkg` holds:
  - State encoding localparams (IDLE=0, SHIFT=1, SETUP=2, LOAD=3, HOLD=4; 3-bit).
  - The counter-width helper.
- One sub-module is natural: `sipo_shreg` (WIDTH-bit shift register with shift enable and synchronous clear). The FSM, the counters and the `d` holding register live in `latch_loader`.

## Test plan
- **Reset**: `rst_n`=0 for 2 cycles with random inputs -> `d`=8'h00, `en`=0, `busy`=0, `done`=0.
- **Nominal load** (WIDTH=8, EN_CYCLES=2): `start`, then bits 1,0,1,0,0,1,0,1 with `sin_valid`=1 every cycle.
  - `d`=8'hA5 one cycle before `en` rises.
  - `en` high exactly 2 cycles.
  - `done` pulses once in the cycle after `en` falls.
  - `d` is stable throughout.
- **Stalls**: same frame with `sin_valid`=0 on alternate cycles -> `d`=8'hA5. `en` rises 2 cycles after the 8th valid bit.
- **Abort**: load 8'h3C, then a new frame aborted after 5 bits.
  - `d` stays 8'h3C; `en` never rises; `busy` falls the next cycle.
  - An abort coincident with the 8th bit also leaves `d`=8'h3C.
- **Reset mid-LOAD**: `rst_n`=0 during the first `en` cycle -> `en`=0 and `d`=0 at the next edge, state IDLE.
- **Back-to-back**: second `start` asserted during LOAD is ignored. A `start` in the first IDLE cycle loads 8'hFF correctly.
